// File: rtl/wam_game_ctrl.sv
// rtl/wam_game_ctrl.sv - Whac-A-Mole round controller: round FSM, score register, countdown control.
// Optional HIGH_SCORE_EN adds a high_score output that tracks the best finished round.
module wam_game_ctrl #(
    parameter int START_TIME   = 60,
    parameter int MISS_PENALTY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       hit,
    input  logic       miss,
    input  logic [5:0] time_left,
    output logic       timer_enable,
    output logic       timer_reset_n,
    output logic [7:0] score,
    output logic [2:0] state,
    output logic       playing,
`ifdef HIGH_SCORE_EN
    output logic [7:0] high_score,
`endif
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [5:0] RELOAD  = 6'(START_TIME);
    localparam logic [8:0] PENALTY = 9'(MISS_PENALTY);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] score_q;
    logic [7:0] score_d;
    logic       rstn_d;
    logic [8:0] score_up;
    logic [8:0] score_dn;

    assign score_up = {1'b0, score_q} + 9'd1;
    assign score_dn = {1'b0, score_q} - PENALTY;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_ARM;
            S_ARM:   if (time_left == RELOAD) state_d = S_PLAY;
            // Timer expiry wins over a simultaneous pause request.
            S_PLAY: begin
                if (time_left == 6'd0) state_d = S_OVER;
                else if (pause)        state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (pause)      state_d = S_PLAY;
                else if (start) state_d = S_ARM;
            end
            S_OVER:  if (start) state_d = S_ARM;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        score_d = score_q;
        if (state_d == S_ARM && state_q != S_ARM) begin
            score_d = 8'd0;
        end else if (state_q == S_PLAY) begin
            if (hit && !miss) begin
                score_d = score_up[8] ? 8'd255 : score_up[7:0];
            end else if (miss && !hit) begin
                score_d = ({1'b0, score_q} < PENALTY) ? 8'd0 : score_dn[7:0];
            end
        end
    end

    // Countdown stays in reload while arming until it reports the full start time.
    always_comb begin
        rstn_d = 1'b1;
        unique case (state_d)
            S_IDLE:  rstn_d = 1'b0;
            S_ARM:   rstn_d = (time_left == RELOAD);
            default: rstn_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            score_q       <= 8'd0;
            timer_enable  <= 1'b0;
            timer_reset_n <= 1'b0;
            playing       <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_q       <= score_d;
            timer_enable  <= (state_d == S_PLAY);
            timer_reset_n <= rstn_d;
            playing       <= (state_d == S_PLAY);
            game_over     <= (state_d == S_OVER);
        end
    end

`ifdef HIGH_SCORE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            high_score <= 8'd0;
        end else if (state_d == S_OVER && state_q != S_OVER && score_d > high_score) begin
            high_score <= score_d;
        end
    end
`endif

    assign state = state_q;
    assign score = score_q;

endmodule
